// File: rtl/sha256_round_ctrl.sv
// Sequencing FSM for one SHA-256 compression pass: round counter control, message-word
// intake gating, schedule select, hash init/update strobes and multi-block chaining.
module sha256_round_ctrl #(
  parameter int unsigned ROUNDS    = 64,
  parameter int unsigned MSG_WORDS = 16,
  parameter int unsigned J_W       = 7
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_start,
  input  logic           i_first,
  input  logic           i_last,
  input  logic           i_abort,
  input  logic           i_msg_valid,
  input  logic [J_W-1:0] j,
  output logic           clr_j,
  output logic           cnt_j_en,
  output logic           o_msg_ready,
  output logic           o_w_sel,
  output logic           o_round_en,
  output logic           o_load_iv,
  output logic           o_load_work,
  output logic           o_hash_upd,
  output logic           o_busy,
  output logic           o_done
);

  localparam logic [J_W-1:0] LastJ = J_W'(ROUNDS - 1);
  localparam logic [J_W-1:0] MsgW  = J_W'(MSG_WORDS);

  typedef enum logic [2:0] {
    StIdle,
    StInit,
    StRound,
    StUpdate,
    StDone
  } state_e;

  state_e state_q, state_d;
  logic   first_q, last_q;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= StIdle;
      first_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && i_start && !i_abort) begin
        first_q <= i_first;
        last_q  <= i_last;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    clr_j       = 1'b0;
    cnt_j_en    = 1'b0;
    o_msg_ready = 1'b0;
    o_w_sel     = 1'b0;
    o_round_en  = 1'b0;
    o_load_iv   = 1'b0;
    o_load_work = 1'b0;
    o_hash_upd  = 1'b0;
    o_busy      = 1'b1;
    o_done      = 1'b0;

    unique case (state_q)
      StIdle: begin
        o_busy = 1'b0;
        clr_j  = 1'b1;
        if (i_start && !i_abort) state_d = StInit;
      end
      StInit: begin
        o_load_iv   = first_q;
        o_load_work = ~first_q;
        state_d     = StRound;
      end
      StRound: begin
        if (j < MsgW) begin
          o_msg_ready = 1'b1;
          o_round_en  = i_msg_valid;
        end else begin
          o_w_sel    = 1'b1;
          o_round_en = 1'b1;
        end
        // Out-of-range j is folded into the last-round case so j can never wrap.
        if (j >= LastJ) begin
          if (o_round_en) state_d = StUpdate;
        end else begin
          cnt_j_en = o_round_en;
        end
      end
      StUpdate: begin
        o_hash_upd = 1'b1;
        clr_j      = 1'b1;
        state_d    = last_q ? StDone : StIdle;
      end
      StDone: begin
        o_done  = 1'b1;
        clr_j   = 1'b1;
        state_d = StIdle;
      end
      default: begin
        clr_j   = 1'b1;
        state_d = StIdle;
      end
    endcase

    if (i_abort && state_q != StIdle) begin
      state_d     = StIdle;
      clr_j       = 1'b1;
      cnt_j_en    = 1'b0;
      o_round_en  = 1'b0;
      o_hash_upd  = 1'b0;
      o_done      = 1'b0;
      o_load_iv   = 1'b0;
      o_load_work = 1'b0;
    end
  end

endmodule
